// File: rtl/csr_pkg.sv
// Shared constants for the CSR commit path: CSR numbers, ecodes,
// writeback op encodings and the commit FSM state encoding.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_TID    = 14'h40;

  localparam logic [5:0] EC_INT = 6'h00;
  localparam logic [5:0] EC_ADE = 6'h08;
  localparam logic [5:0] EC_ALE = 6'h09;
  localparam logic [5:0] EC_BRK = 6'h0C;
  localparam logic [5:0] EC_INE = 6'h0D;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_RDCNTVL = 3'd5,
    OP_RDCNTVH = 3'd6,
    OP_RDCNTID = 3'd7
  } ws_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_ERTN_FIN = 2'd2,
    ST_DISCARD  = 2'd3
  } state_e;

  // Writes to these CSRs can change interrupt enables or pending state,
  // so younger bundles must be refetched.
  function automatic logic is_int_ctl_csr(input logic [13:0] num);
    return (num == CSR_CRMD) || (num == CSR_ECFG) || (num == CSR_ESTAT);
  endfunction

  function automatic logic op_writes_rf(input ws_op_e op);
    return (op != OP_NONE) && (op != OP_ERTN);
  endfunction

endpackage

// File: rtl/csr_commit_ctrl.sv
// Writeback-stage CSR commit controller: turns a latched WB bundle into
// CSR read/write strobes, GPR writeback, exception/ERTN commits and
// fetch redirects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no bundle held, ready for the next one
// EXEC     | latched bundle drives its CSR/RF/commit outputs this cycle
// ERTN_FIN | ERA captured, pulse ertn_flush + redirect to ERA
// DISCARD  | drop wrong-path bundles until pc == redirect target
module csr_commit_ctrl
  import csr_pkg::*;
#(
  parameter logic [5:0]  ECODE_INT   = EC_INT,
  parameter logic [13:0] CSR_ERA_NUM = CSR_ERA,
  parameter logic [13:0] CSR_TID_NUM = CSR_TID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  logic [2:0]  ws_op,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rj_value,
  input  logic [31:0] ws_rd_value,
  input  logic [4:0]  ws_dest,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  input  logic [31:0] csr_eentry,
  input  logic        has_int,
  input  logic [63:0] stable_counter_value,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_pc
);

  state_e      r_state;
  state_e      w_state_nxt;

  logic [31:0] r_pc;
  ws_op_e      r_op;
  logic [13:0] r_num;
  logic [31:0] r_rj;
  logic [31:0] r_rd;
  logic [4:0]  r_dest;
  logic        r_ex;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esub;
  logic [31:0] r_vaddr;
  logic [31:0] r_era;
  logic [31:0] r_flush_pc;

  logic        w_trap;
  logic        w_csr_wr;
  logic        w_csr_flush;
  logic        w_ertn;
  logic        w_redirect;
  logic        w_accept;

  // Decode of the latched bundle; only meaningful while in EXEC.
  always_comb begin
    w_trap      = has_int | r_ex;
    w_csr_wr    = (r_op == OP_CSRWR) || (r_op == OP_CSRXCHG);
    w_csr_flush = w_csr_wr && is_int_ctl_csr(r_num) && !w_trap;
    w_ertn      = (r_op == OP_ERTN) && !w_trap;
    w_redirect  = w_trap || w_csr_flush || w_ertn;
    w_accept    = ws_valid && ws_ready &&
                  ((r_state != ST_DISCARD) || (ws_pc == r_flush_pc));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        if (w_trap || w_csr_flush) w_state_nxt = ST_DISCARD;
        else if (w_ertn)           w_state_nxt = ST_ERTN_FIN;
        else if (w_accept)         w_state_nxt = ST_EXEC;
        else                       w_state_nxt = ST_IDLE;
      end
      ST_ERTN_FIN: w_state_nxt = ST_DISCARD;
      ST_DISCARD:  w_state_nxt = w_accept ? ST_EXEC : ST_DISCARD;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; reset suppresses every pulse so an interrupted ERTN never redirects.
  always_comb begin
    ws_ready    = 1'b0;
    csr_re      = 1'b0;
    csr_we      = 1'b0;
    csr_num     = 14'd0;
    csr_wmask   = 32'd0;
    csr_wvalue  = 32'd0;
    wb_ex       = 1'b0;
    ertn_flush  = 1'b0;
    wb_ecode    = 6'd0;
    wb_esubcode = 9'd0;
    wb_pc       = 32'd0;
    wb_vaddr    = 32'd0;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    flush       = 1'b0;
    flush_pc    = r_flush_pc;
    if (reset) begin
      ws_ready = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DISCARD: ws_ready = 1'b1;
        ST_EXEC: begin
          ws_ready = !w_redirect;
          if (w_trap) begin
            wb_ex       = 1'b1;
            wb_ecode    = has_int ? ECODE_INT : r_ecode;
            wb_esubcode = has_int ? 9'd0 : r_esub;
            wb_pc       = r_pc;
            wb_vaddr    = has_int ? 32'd0 : r_vaddr;
            flush       = 1'b1;
            flush_pc    = csr_eentry;
          end else begin
            case (r_op)
              OP_CSRRD, OP_CSRWR, OP_CSRXCHG: begin
                csr_re   = 1'b1;
                csr_num  = r_num;
                rf_wdata = csr_rvalue;
                if (w_csr_wr) begin
                  csr_we     = 1'b1;
                  csr_wmask  = (r_op == OP_CSRWR) ? 32'hFFFF_FFFF : r_rj;
                  csr_wvalue = r_rd;
                end
                if (w_csr_flush) begin
                  flush    = 1'b1;
                  flush_pc = r_pc + 32'd4;
                end
              end
              OP_ERTN: begin
                csr_re  = 1'b1;
                csr_num = CSR_ERA_NUM;
              end
              OP_RDCNTVL: rf_wdata = stable_counter_value[31:0];
              OP_RDCNTVH: rf_wdata = stable_counter_value[63:32];
              OP_RDCNTID: begin
                csr_re   = 1'b1;
                csr_num  = CSR_TID_NUM;
                rf_wdata = csr_rvalue;
              end
              default: ;
            endcase
            if (op_writes_rf(r_op) && (r_dest != 5'd0)) begin
              rf_we    = 1'b1;
              rf_waddr = r_dest;
            end
          end
        end
        ST_ERTN_FIN: begin
          ertn_flush = 1'b1;
          flush      = 1'b1;
          flush_pc   = r_era;
        end
        default: ;
      endcase
    end
  end

  // Latch the accepted bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= 32'd0;
      r_op    <= OP_NONE;
      r_num   <= 14'd0;
      r_rj    <= 32'd0;
      r_rd    <= 32'd0;
      r_dest  <= 5'd0;
      r_ex    <= 1'b0;
      r_ecode <= 6'd0;
      r_esub  <= 9'd0;
      r_vaddr <= 32'd0;
    end else if (w_accept) begin
      r_pc    <= ws_pc;
      r_op    <= ws_op_e'(ws_op);
      r_num   <= ws_csr_num;
      r_rj    <= ws_rj_value;
      r_rd    <= ws_rd_value;
      r_dest  <= ws_dest;
      r_ex    <= ws_ex;
      r_ecode <= ws_ecode;
      r_esub  <= ws_esubcode;
      r_vaddr <= ws_vaddr;
    end
  end

  // Capture ERA during the ERTN read and remember every redirect target for DISCARD matching.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_era      <= 32'd0;
      r_flush_pc <= 32'd0;
    end else begin
      if ((r_state == ST_EXEC) && w_ertn) r_era <= csr_rvalue;
      if (flush) r_flush_pc <= flush_pc;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed bench for csr_commit_ctrl; the bench plays the CSR file and counter.
module tb_csr_commit_ctrl;
  import csr_pkg::*;

  logic        clk;
  logic        reset;
  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  logic [2:0]  ws_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rd_value;
  logic [4:0]  ws_dest;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_vaddr;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic [31:0] csr_eentry;
  logic        has_int;
  logic [63:0] stable_counter_value;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fails  = 0;

  csr_commit_ctrl u_dut (
    .clk(clk), .reset(reset),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_op(ws_op),
    .ws_csr_num(ws_csr_num), .ws_rj_value(ws_rj_value), .ws_rd_value(ws_rd_value),
    .ws_dest(ws_dest), .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
    .ws_vaddr(ws_vaddr),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .csr_eentry(csr_eentry),
    .has_int(has_int), .stable_counter_value(stable_counter_value),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_pc(flush_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [2:0] op, input logic [31:0] pc, input logic [13:0] num,
                        input logic [31:0] rj, input logic [31:0] rd, input logic [4:0] dest);
    ws_valid    = 1'b1;
    ws_op       = op;
    ws_pc       = pc;
    ws_csr_num  = num;
    ws_rj_value = rj;
    ws_rd_value = rd;
    ws_dest     = dest;
    ws_ex       = 1'b0;
    ws_ecode    = 6'd0;
    ws_esubcode = 9'd0;
    ws_vaddr    = 32'd0;
  endtask

  task automatic no_bundle();
    ws_valid = 1'b0;
    ws_ex    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ws_valid = 1'b0; ws_pc = 32'd0; ws_op = 3'd0; ws_csr_num = 14'd0;
    ws_rj_value = 32'd0; ws_rd_value = 32'd0; ws_dest = 5'd0; ws_ex = 1'b0;
    ws_ecode = 6'd0; ws_esubcode = 9'd0; ws_vaddr = 32'd0;
    csr_rvalue = 32'd0; csr_eentry = 32'd0; has_int = 1'b0; stable_counter_value = 64'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ready", ws_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_wb_ex", wb_ex, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_csr_we", csr_we, 0);
    check("rst_rf_we", rf_we, 0);

    // CSRWR to a plain CSR: old value returned, no redirect
    bundle(OP_CSRWR, 32'h1C00_0000, 14'h30, 32'd0, 32'h1234_5678, 5'd5);
    #1 check("wr_ready_idle", ws_ready, 1);
    tick();
    no_bundle();
    csr_rvalue = 32'hA5;
    #1;
    check("wr_csr_re", csr_re, 1);
    check("wr_csr_num", csr_num, 14'h30);
    check("wr_csr_we", csr_we, 1);
    check("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
    check("wr_wvalue", csr_wvalue, 32'h1234_5678);
    check("wr_rf_we", rf_we, 1);
    check("wr_rf_waddr", rf_waddr, 5);
    check("wr_rf_wdata", rf_wdata, 32'hA5);
    check("wr_flush", flush, 0);
    check("wr_ready", ws_ready, 1);
    tick();

    // back-to-back RDCNTVH, dest 4 then dest 0
    stable_counter_value = 64'h0000_0002_FFFF_FFFF;
    bundle(OP_RDCNTVH, 32'h1C00_0010, 14'd0, 32'd0, 32'd0, 5'd4);
    tick();
    bundle(OP_RDCNTVH, 32'h1C00_0014, 14'd0, 32'd0, 32'd0, 5'd0);
    #1;
    check("cnth_rf_we", rf_we, 1);
    check("cnth_waddr", rf_waddr, 4);
    check("cnth_wdata", rf_wdata, 32'd2);
    check("cnth_ready", ws_ready, 1);
    tick();
    no_bundle();
    #1 check("cnth_dest0_rf_we", rf_we, 0);
    tick();
    has_int = 1'b1;
    #1 check("idle_int_ignored", wb_ex, 0);
    has_int = 1'b0;

    // CSRXCHG to ECFG: redirect to pc+4, wrong-path bundle dropped
    bundle(OP_CSRXCHG, 32'h1C00_0100, 14'h4, 32'h0000_0800, 32'hFFFF_FFFF, 5'd0);
    tick();
    bundle(OP_CSRRD, 32'h1C00_0200, 14'h30, 32'd0, 32'd0, 5'd3);
    #1;
    check("xchg_csr_we", csr_we, 1);
    check("xchg_wmask", csr_wmask, 32'h800);
    check("xchg_wvalue", csr_wvalue, 32'hFFFF_FFFF);
    check("xchg_flush", flush, 1);
    check("xchg_flush_pc", flush_pc, 32'h1C00_0104);
    check("xchg_ready", ws_ready, 0);
    tick();
    #1;
    check("disc_ready", ws_ready, 1);
    check("disc_flush", flush, 0);
    check("disc_rf_we", rf_we, 0);
    tick();
    #1;
    check("drop_rf_we", rf_we, 0);
    check("drop_csr_re", csr_re, 0);
    bundle(OP_CSRRD, 32'h1C00_0104, 14'h30, 32'd0, 32'd0, 5'd7);
    csr_rvalue = 32'h55;
    tick();
    no_bundle();
    #1;
    check("resume_rf_we", rf_we, 1);
    check("resume_waddr", rf_waddr, 7);
    check("resume_wdata", rf_wdata, 32'h55);
    tick();

    // upstream exception (ALE)
    bundle(OP_CSRRD, 32'h1C00_0300, 14'h30, 32'd0, 32'd0, 5'd2);
    ws_ex = 1'b1; ws_ecode = 6'h9; ws_esubcode = 9'd0; ws_vaddr = 32'h1003;
    tick();
    no_bundle();
    csr_eentry = 32'h1C00_8000;
    #1;
    check("ex_wb_ex", wb_ex, 1);
    check("ex_ecode", wb_ecode, 6'h9);
    check("ex_vaddr", wb_vaddr, 32'h1003);
    check("ex_pc", wb_pc, 32'h1C00_0300);
    check("ex_flush", flush, 1);
    check("ex_flush_pc", flush_pc, 32'h1C00_8000);
    check("ex_rf_we", rf_we, 0);
    check("ex_csr_we", csr_we, 0);
    tick();
    bundle(OP_NONE, 32'h1C00_8000, 14'd0, 32'd0, 32'd0, 5'd0);
    tick();
    no_bundle();
    #1 check("ex_handler_rf_we", rf_we, 0);
    tick();

    // ERTN: ERA read in N+1, redirect in N+2
    bundle(OP_ERTN, 32'h1C00_0400, 14'd0, 32'd0, 32'd0, 5'd0);
    tick();
    csr_rvalue = 32'h1C00_0040;
    stable_counter_value = 64'h0000_0007_1234_0000;
    bundle(OP_RDCNTVL, 32'h1C00_0040, 14'd0, 32'd0, 32'd0, 5'd9);
    #1;
    check("ertn_csr_re", csr_re, 1);
    check("ertn_csr_num", csr_num, 14'h6);
    check("ertn_ready_n1", ws_ready, 0);
    check("ertn_flush_n1", flush, 0);
    check("ertn_eflush_n1", ertn_flush, 0);
    check("ertn_rf_we", rf_we, 0);
    tick();
    csr_rvalue = 32'hDEAD_BEEF;
    #1;
    check("ertn_eflush_n2", ertn_flush, 1);
    check("ertn_flush_n2", flush, 1);
    check("ertn_flush_pc", flush_pc, 32'h1C00_0040);
    check("ertn_ready_n2", ws_ready, 0);
    tick();
    #1;
    check("ertn_eflush_done", ertn_flush, 0);
    check("ertn_disc_ready", ws_ready, 1);
    tick();
    no_bundle();
    #1;
    check("ertn_tgt_rf_we", rf_we, 1);
    check("ertn_tgt_waddr", rf_waddr, 9);
    check("ertn_tgt_wdata", rf_wdata, 32'h1234_0000);
    tick();

    // interrupt beats a CSRRD; ignored in DISCARD
    bundle(OP_CSRRD, 32'h1C00_0500, 14'h30, 32'd0, 32'd0, 5'd3);
    tick();
    no_bundle();
    has_int = 1'b1;
    csr_eentry = 32'h1C00_8000;
    #1;
    check("int_wb_ex", wb_ex, 1);
    check("int_ecode", wb_ecode, 6'h0);
    check("int_esub", wb_esubcode, 9'd0);
    check("int_pc", wb_pc, 32'h1C00_0500);
    check("int_flush", flush, 1);
    check("int_flush_pc", flush_pc, 32'h1C00_8000);
    check("int_rf_we", rf_we, 0);
    tick();
    bundle(OP_CSRRD, 32'h1C00_0504, 14'h30, 32'd0, 32'd0, 5'd3);
    #1;
    check("int_disc_wb_ex", wb_ex, 0);
    check("int_disc_flush", flush, 0);
    tick();
    #1;
    check("int_drop_wb_ex", wb_ex, 0);
    check("int_drop_rf_we", rf_we, 0);
    has_int = 1'b0;
    bundle(OP_NONE, 32'h1C00_8000, 14'd0, 32'd0, 32'd0, 5'd0);
    tick();
    no_bundle();
    tick();

    // CSRWR to CRMD at the top of the address space: pc+4 wraps to 0
    bundle(OP_CSRWR, 32'hFFFF_FFFC, 14'h0, 32'd0, 32'd1, 5'd1);
    tick();
    no_bundle();
    csr_rvalue = 32'd0;
    #1;
    check("wrap_csr_we", csr_we, 1);
    check("wrap_flush", flush, 1);
    check("wrap_flush_pc", flush_pc, 32'd0);
    check("wrap_rf_we", rf_we, 1);
    tick();
    bundle(OP_NONE, 32'd0, 14'd0, 32'd0, 32'd0, 5'd0);
    tick();
    no_bundle();
    tick();

    // reset while in ERTN_FIN suppresses the redirect
    bundle(OP_ERTN, 32'h1C00_0600, 14'd0, 32'd0, 32'd0, 5'd0);
    tick();
    no_bundle();
    csr_rvalue = 32'h1C00_0700;
    tick();
    reset = 1'b1;
    #1;
    check("rstfin_eflush", ertn_flush, 0);
    check("rstfin_flush", flush, 0);
    tick();
    reset = 1'b0;
    #1;
    check("rstfin_ready", ws_ready, 1);
    check("rstfin_flush_after", flush, 0);
    check("rstfin_eflush_after", ertn_flush, 0);
    check("rstfin_flush_pc", flush_pc, 0);
    tick();
    check("rstfin_idle_flush", flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/csr_commit_ctrl.md
Name: csr_commit_ctrl

Overview:
- Writeback-stage initiator for the CSR register file: turns committed instruction bundles into CSR read/write strobes, exception/ERTN commits and pipeline redirects.
- Drives csr_re/csr_num/csr_we/csr_wmask/csr_wvalue, wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr and ertn_flush.
- Consumes csr_rvalue, csr_eentry, has_int and stable_counter_value.
- Sits between the MEM→WB pipeline register and the register file / fetch redirect.

Parameters:
- ECODE_INT, 6'h00, ecode committed for interrupts
- CSR_ERA_NUM, 14'h6, CSR number read to obtain the ERTN target
- CSR_TID_NUM, 14'h40, CSR number read by RDCNTID

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_valid  in  1  bundle valid from MEM stage
- ws_ready  out  1  bundle accepted when ws_valid&&ws_ready
- ws_pc  in  32  instruction PC
- ws_op  in  3  0 NONE, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN, 5 RDCNTVL, 6 RDCNTVH, 7 RDCNTID
- ws_csr_num  in  14  CSR index
- ws_rj_value  in  32  write mask for CSRXCHG
- ws_rd_value  in  32  write data for CSRWR/CSRXCHG
- ws_dest  in  5  destination GPR; 0 means no writeback
- ws_ex  in  1  upstream exception
- ws_ecode  in  6  upstream ecode
- ws_esubcode  in  9  upstream esubcode
- ws_vaddr  in  32  faulting data address
- csr_re, csr_we  out  1  CSR read/write strobes
- csr_num  out  14  CSR index
- csr_wmask, csr_wvalue  out  32  CSR write mask/data
- csr_rvalue  in  32  CSR read data, same cycle
- csr_eentry  in  32  exception entry
- has_int  in  1  pending enabled interrupt
- stable_counter_value  in  64  constant-rate counter
- wb_ex, ertn_flush  out  1  single-cycle commit pulses
- wb_ecode  out  6; wb_esubcode  out  9; wb_pc, wb_vaddr  out  32
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  GPR writeback
- flush  out  1  single-cycle redirect pulse
- flush_pc  out  32  redirect target, valid with flush

Behaviour:
- Reset: state IDLE; ws_ready=1; every pulse/strobe output 0; latched bundle invalid; flush_pc=0.
- States: IDLE, EXEC, ERTN_FIN, DISCARD.
- Acceptance: the bundle accepted in cycle N is latched. All of its CSR/RF/commit outputs occur combinationally from the latched bundle in N+1 (EXEC). ERTN completes in N+2.
- EXEC priority 1, interrupt: has_int=1 sampled in EXEC. Assert wb_ex with wb_ecode=ECODE_INT, esubcode 0 and wb_pc=latched pc. Also assert flush with flush_pc=csr_eentry. No csr_we, no rf_we. Next state DISCARD.
- EXEC priority 2, exception: ws_ex latched. Same as priority 1 but with the latched ecode/esubcode; wb_vaddr=latched vaddr.
- CSRRD/CSRWR/CSRXCHG: csr_re=1, csr_num=latched num, rf_wdata=csr_rvalue (old value).
  - CSRWR: csr_we=1, wmask=32'hFFFFFFFF, wvalue=rd_value.
  - CSRXCHG: csr_we=1, wmask=rj_value, wvalue=rd_value.
  - A write to CSR 0x0, 0x4 or 0x5 also pulses flush with flush_pc=pc+4, then goes to DISCARD (IE/LIE/IS may change).
- RDCNTVL / RDCNTVH: rf_wdata = stable_counter_value[31:0] / [63:32].
- RDCNTID: csr_re=1, csr_num=CSR_TID_NUM, rf_wdata=csr_rvalue.
- rf_we=1 only in EXEC, with no exception, for ops 1,2,3,5,6,7, and ws_dest!=0. rf_waddr=latched dest.
- ERTN: in EXEC, csr_re=1, csr_num=CSR_ERA_NUM, latch csr_rvalue as target; no rf_we; go to ERTN_FIN. In ERTN_FIN, pulse ertn_flush and flush with flush_pc=latched ERA, then go to DISCARD.
- ws_ready: 1 in IDLE and DISCARD. In EXEC, 1 only when the current bundle causes no flush/ERTN, giving 1 bundle/cycle back-to-back. 0 in ERTN_FIN and in a flushing EXEC.
- DISCARD: accepted bundles are dropped with no side effects, until one arrives with ws_pc==flush_pc. That bundle is latched and goes to EXEC normally.
- has_int is ignored in IDLE, ERTN_FIN and DISCARD; it is only taken against a real bundle in EXEC.
- EXEC with no next bundle goes to IDLE.
- Reset mid-operation, including in ERTN_FIN: return to IDLE with no ertn_flush/flush pulse emitted.
- PC arithmetic is mod 2^32 (pc 32'hFFFFFFFC + 4 = 0).

Decomposition:
- Shared package csr_pkg: CSR number constants (CRMD 0x0, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, TID 0x40), ecode constants (INT 0x0, ADE 0x8, ALE 0x9, BRK 0xC, INE 0xD), ws_op encodings, state encoding.
- No sub-module; single FSM plus latch register. The CSR file remains a separate instance.

Test Plan:
- CSRWR num 0x30, rd_value 0x1234_5678, save0 previously 0xA5 → cycle N+1: csr_we=1, wmask=FFFFFFFF, wvalue=0x12345678; rf_wdata=0xA5 with rf_we=1. No flush.
- CSRXCHG num 0x4, rj 0x0000_0800, rd 0xFFFF_FFFF, pc 0x1C00_0100 → csr_we, wmask 0x800, flush=1, flush_pc=0x1C00_0104. Following bundles with pc≠0x1C000104 are dropped (no rf_we).
- Bundle with ws_ex=1, ecode 0x9, vaddr 0x1003, eentry 0x1C00_8000 → wb_ex=1, wb_ecode=9, wb_vaddr=0x1003, flush_pc=0x1C00_8000, rf_we=0.
- ERTN with ERA=0x1C00_0040 → N+1: csr_re, csr_num=6; N+2: ertn_flush=flush=1, flush_pc=0x1C00_0040; ws_ready=0 during N+1..N+2.
- has_int=1 with a CSRRD in EXEC → interrupt wins: wb_ecode=0, no rf_we. Same has_int during DISCARD → no wb_ex.
- RDCNTVH with counter 0x0000_0002_FFFF_FFFF, dest 4 → rf_waddr=4, rf_wdata=2. With dest 0 → rf_we=0. Reset asserted in ERTN_FIN → no pulses, ws_ready=1 next cycle.
